// File: rtl/ex_stage.sv
// Execute stage + EX/MEM register; optional iterative multu with HI/LO (EX_MULT_EN).
// Latency: one negedge from capture to EX/MEM outputs; multu stalls 32 enabled cycles.
// Backpressure: hit low freezes all state; stall (registered) holds the upstream IF/ID and ID/EX.
module ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             hit,
   input  logic [WIDTH-1:0] readData1,
   input  logic [WIDTH-1:0] readData2,
   input  logic [WIDTH-1:0] signExImmediate,
   input  logic             regDst,
   input  logic             aluSrc,
   input  logic             memToReg,
   input  logic             regWrite,
   input  logic             memRead,
   input  logic             memWrite,
   input  logic             branch,
   input  logic [2:0]       aluOp,
   input  logic [4:0]       rt,
   input  logic [4:0]       rd,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] nextPc,
   output logic [WIDTH-1:0] aluResultOut,
   output logic [WIDTH-1:0] writeDataOut,
   output logic [4:0]       writeRegOut,
   output logic [WIDTH-1:0] branchTargetOut,
   output logic             zeroOut,
   output logic             memToRegOut,
   output logic             regWriteOut,
   output logic             memReadOut,
   output logic             memWriteOut,
   output logic             branchOut,
   output logic             stall
);

   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] aluResult;
   logic             isMultu;
   logic             busy;

`ifdef EX_MULT_EN
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic {IDLE, BUSY} mulState_t;

   mulState_t          state, stateNext;
   logic [CW-1:0]      stepCnt;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] accNext;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;

   assign busy = (state == BUSY);
`else
   assign busy = 1'b0;
`endif

   assign stall = busy;

   always_comb begin
      opB       = aluSrc ? signExImmediate : readData2;
      aluResult = '0;
      isMultu   = 1'b0;
      case (aluOp)
         3'b000, 3'b111: aluResult = readData1 + opB;
         3'b001:         aluResult = readData1 - opB;
         3'b010: begin
            case (funct)
               6'h20:   aluResult = readData1 + opB;
               6'h22:   aluResult = readData1 - opB;
               6'h24:   aluResult = readData1 & opB;
               6'h25:   aluResult = readData1 | opB;
               6'h27:   aluResult = ~(readData1 | opB);
               6'h2A:   aluResult = {{(WIDTH-1){1'b0}}, $signed(readData1) < $signed(opB)};
`ifdef EX_MULT_EN
               6'h10:   aluResult = hiReg;
               6'h12:   aluResult = loReg;
               6'h19:   isMultu   = 1'b1;
`endif
               default: aluResult = '0;
            endcase
         end
         3'b011:  aluResult = readData1 & opB;
         3'b100:  aluResult = readData1 | opB;
         3'b101:  aluResult = {{(WIDTH-1){1'b0}}, $signed(readData1) < $signed(opB)};
         3'b110:  aluResult = opB << 16;
         default: aluResult = '0;
      endcase
   end

   // EX/MEM register: bubbles while the multiplier owns the stage, data fields hold.
   always_ff @(negedge CLK) begin
      if (RST) begin
         aluResultOut    <= '0;
         writeDataOut    <= '0;
         writeRegOut     <= '0;
         branchTargetOut <= '0;
         zeroOut         <= 1'b0;
         memToRegOut     <= 1'b0;
         regWriteOut     <= 1'b0;
         memReadOut      <= 1'b0;
         memWriteOut     <= 1'b0;
         branchOut       <= 1'b0;
      end else if (hit) begin
         if (busy) begin
            zeroOut     <= 1'b0;
            memToRegOut <= 1'b0;
            regWriteOut <= 1'b0;
            memReadOut  <= 1'b0;
            memWriteOut <= 1'b0;
            branchOut   <= 1'b0;
         end else begin
            aluResultOut    <= aluResult;
            writeDataOut    <= readData2;
            writeRegOut     <= regDst ? rd : rt;
            branchTargetOut <= nextPc + (signExImmediate << 2);
            zeroOut         <= (aluResult == '0);
            memToRegOut     <= memToReg;
            regWriteOut     <= regWrite & ~isMultu;
            memReadOut      <= memRead & ~isMultu;
            memWriteOut     <= memWrite & ~isMultu;
            branchOut       <= branch & ~isMultu;
         end
      end
   end

`ifdef EX_MULT_EN
   assign accNext = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (hit && isMultu) stateNext = BUSY;
         BUSY:    if (hit && stepCnt == LAST_STEP) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // One shift-add step per enabled edge, multiplier consumed LSB first.
   always_ff @(negedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         stepCnt <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         hiReg   <= '0;
         loReg   <= '0;
      end else if (hit) begin
         state <= stateNext;
         if (state == IDLE) begin
            if (isMultu) begin
               mcand   <= {{WIDTH{1'b0}}, readData1};
               mplier  <= opB;
               acc     <= '0;
               stepCnt <= '0;
            end
         end else begin
            acc     <= accNext;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            stepCnt <= stepCnt + 1'b1;
            if (stepCnt == LAST_STEP) begin
               hiReg <= accNext[2*WIDTH-1:WIDTH];
               loReg <= accNext[WIDTH-1:0];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for the ALU/EX-MEM path plus multiply sequences.
// Inputs change at posedge, the DUT updates at negedge, outputs are sampled at the next posedge.
// Multiplier sequences run when EX_MULT_EN is defined; otherwise the disabled behaviour is checked.
module tb_ex_stage;

   logic        CLK = 1'b0;
   logic        RST, hit;
   logic [31:0] readData1, readData2, signExImmediate, nextPc;
   logic        regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch;
   logic [2:0]  aluOp;
   logic [4:0]  rt, rd;
   logic [5:0]  funct;
   logic [31:0] aluResultOut, writeDataOut, branchTargetOut;
   logic [4:0]  writeRegOut;
   logic        zeroOut, memToRegOut, regWriteOut, memReadOut, memWriteOut, branchOut, stall;

   int tests = 0;
   int fails = 0;

   ex_stage #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .hit(hit),
      .readData1(readData1), .readData2(readData2), .signExImmediate(signExImmediate),
      .regDst(regDst), .aluSrc(aluSrc), .memToReg(memToReg), .regWrite(regWrite),
      .memRead(memRead), .memWrite(memWrite), .branch(branch),
      .aluOp(aluOp), .rt(rt), .rd(rd), .funct(funct), .nextPc(nextPc),
      .aluResultOut(aluResultOut), .writeDataOut(writeDataOut), .writeRegOut(writeRegOut),
      .branchTargetOut(branchTargetOut), .zeroOut(zeroOut),
      .memToRegOut(memToRegOut), .regWriteOut(regWriteOut), .memReadOut(memReadOut),
      .memWriteOut(memWriteOut), .branchOut(branchOut), .stall(stall)
   );

   always #5 CLK = ~CLK;

   // ctl / eCtl = {memToReg, regWrite, memRead, memWrite, branch}
   typedef struct packed {
      logic [2:0]  aluOp;
      logic [5:0]  funct;
      logic [31:0] a, b, imm, pc;
      logic        aluSrc, regDst;
      logic [4:0]  rt, rd;
      logic [4:0]  ctl;
      logic [31:0] eRes;
      logic        eZero;
      logic [4:0]  eWr;
      logic [31:0] eBt;
      logic [4:0]  eCtl;
   } vec_t;

   vec_t vecs [16];

   function automatic logic [4:0] ctlOut();
      return {memToRegOut, regWriteOut, memReadOut, memWriteOut, branchOut};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      @(posedge CLK);
   endtask

   task automatic drive(input vec_t v);
      aluOp = v.aluOp; funct = v.funct;
      readData1 = v.a; readData2 = v.b; signExImmediate = v.imm; nextPc = v.pc;
      aluSrc = v.aluSrc; regDst = v.regDst; rt = v.rt; rd = v.rd;
      {memToReg, regWrite, memRead, memWrite, branch} = v.ctl;
   endtask

   function automatic vec_t rType(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] dst, input logic [4:0] ctl);
      vec_t v;
      v = '0;
      v.aluOp = 3'b010; v.funct = f; v.a = a; v.b = b;
      v.regDst = 1'b1; v.rd = dst; v.rt = 5'd30; v.ctl = ctl;
      return v;
   endfunction

   initial begin
      // aluOp funct a b imm pc aluSrc regDst rt rd ctl | eRes eZero eWr eBt eCtl
      vecs[0]  = '{3'd2, 6'h20, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 5'd9, 5'd3, 5'b01000,
                   32'd12, 1'b0, 5'd3, 32'd0, 5'b01000};
      vecs[1]  = '{3'd1, 6'h00, 32'd9, 32'd9, 32'd4, 32'h100, 1'b0, 1'b0, 5'd2, 5'd7, 5'b00001,
                   32'd0, 1'b1, 5'd2, 32'h110, 5'b00001};
      vecs[2]  = '{3'd2, 6'h22, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd5, 5'b01000,
                   32'hFFFF_FFFE, 1'b0, 5'd5, 32'd0, 5'b01000};
      vecs[3]  = '{3'd2, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h20, 32'h400, 1'b0, 1'b1, 5'd0, 5'd6,
                   5'b01000, 32'hF000_F000, 1'b0, 5'd6, 32'h480, 5'b01000};
      vecs[4]  = '{3'd2, 6'h25, 32'h0F, 32'hF0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd8, 5'b01000,
                   32'hFF, 1'b0, 5'd8, 32'd0, 5'b01000};
      vecs[5]  = '{3'd2, 6'h27, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd10, 5'b01000,
                   32'hFFFF_FFFF, 1'b0, 5'd10, 32'd0, 5'b01000};
      vecs[6]  = '{3'd2, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd11, 5'b01000,
                   32'd1, 1'b0, 5'd11, 32'd0, 5'b01000};
      vecs[7]  = '{3'd2, 6'h2A, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd12, 5'b01000,
                   32'd0, 1'b1, 5'd12, 32'd0, 5'b01000};
      vecs[8]  = '{3'd0, 6'h00, 32'h1000, 32'h55, 32'hFFFF_FFFC, 32'h200, 1'b1, 1'b0, 5'd13, 5'd0,
                   5'b11100, 32'hFFC, 1'b0, 5'd13, 32'h1F0, 5'b11100};
      vecs[9]  = '{3'd7, 6'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd14, 5'b01000,
                   32'd0, 1'b1, 5'd14, 32'd0, 5'b01000};
      vecs[10] = '{3'd3, 6'h00, 32'hC, 32'hA, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd15, 5'b01000,
                   32'h8, 1'b0, 5'd15, 32'd0, 5'b01000};
      vecs[11] = '{3'd4, 6'h00, 32'h1, 32'h0, 32'h10, 32'd0, 1'b1, 1'b0, 5'd16, 5'd0, 5'b01000,
                   32'h11, 1'b0, 5'd16, 32'h40, 5'b01000};
      vecs[12] = '{3'd5, 6'h00, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd17,
                   5'b01000, 32'd1, 1'b0, 5'd17, 32'd0, 5'b01000};
      vecs[13] = '{3'd6, 6'h00, 32'd0, 32'd0, 32'h1234, 32'd0, 1'b1, 1'b0, 5'd18, 5'd0, 5'b01000,
                   32'h1234_0000, 1'b0, 5'd18, 32'h48D0, 5'b01000};
      vecs[14] = '{3'd2, 6'h3F, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd19, 5'b01000,
                   32'd0, 1'b1, 5'd19, 32'd0, 5'b01000};
      vecs[15] = '{3'd1, 6'h00, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd20, 5'd0, 5'b00010,
                   32'hFFFF_FFFF, 1'b0, 5'd20, 32'd0, 5'b00010};

      // Load a non-zero state, then reset with random inputs.
      RST = 1'b0; hit = 1'b1;
      drive(vecs[3]);
      tick();
      RST = 1'b1;
      readData1 = $urandom; readData2 = $urandom; signExImmediate = $urandom; nextPc = $urandom;
      {memToReg, regWrite, memRead, memWrite, branch} = 5'($urandom);
      aluOp = 3'($urandom); funct = 6'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      regDst = 1'($urandom); aluSrc = 1'($urandom);
      tick();
      chk("reset res", aluResultOut, 32'd0);
      chk("reset wdata", writeDataOut, 32'd0);
      chk("reset wreg", {27'd0, writeRegOut}, 32'd0);
      chk("reset btarget", branchTargetOut, 32'd0);
      chk("reset ctl/zero/stall", {25'd0, zeroOut, ctlOut(), stall}, 32'd0);
      RST = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i]);
         tick();
         chk($sformatf("v%0d res", i), aluResultOut, vecs[i].eRes);
         chk($sformatf("v%0d zero", i), {31'd0, zeroOut}, {31'd0, vecs[i].eZero});
         chk($sformatf("v%0d wreg", i), {27'd0, writeRegOut}, {27'd0, vecs[i].eWr});
         chk($sformatf("v%0d wdata", i), writeDataOut, vecs[i].b);
         chk($sformatf("v%0d btarget", i), branchTargetOut, vecs[i].eBt);
         chk($sformatf("v%0d ctl", i), {27'd0, ctlOut()}, {27'd0, vecs[i].eCtl});
         chk($sformatf("v%0d stall", i), {31'd0, stall}, 32'd0);
      end

      // hit low holds everything; reset overrides a low hit.
      hit = 1'b0;
      drive(vecs[0]);
      tick();
      chk("hold res", aluResultOut, 32'hFFFF_FFFF);
      chk("hold wreg", {27'd0, writeRegOut}, 32'd20);
      chk("hold ctl", {27'd0, ctlOut()}, 32'b00010);
      RST = 1'b1;
      tick();
      chk("reset over hit res", aluResultOut, 32'd0);
      chk("reset over hit ctl", {27'd0, ctlOut()}, 32'd0);
      RST = 1'b0; hit = 1'b1;

`ifdef EX_MULT_EN
      begin
         vec_t mv;
         int   cyc;
         logic bad;

         // multu 0xFFFFFFFF x 2, then mfhi / mflo held behind the stall.
         mv = rType(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd21, 5'b11011);
         drive(mv);
         tick();
         chk("multu ctl forced", {27'd0, ctlOut()}, 32'b10000);
         chk("multu stall", {31'd0, stall}, 32'd1);
         drive(rType(6'h10, 32'd0, 32'd0, 5'd4, 5'b01000));
         cyc = 0; bad = 1'b0;
         while (stall && cyc < 100) begin
            cyc++;
            tick();
            if (ctlOut() != 5'd0 || zeroOut != 1'b0) bad = 1'b1;
         end
         chk("multu stall cycles", cyc, 32'd32);
         chk("multu bubbles", {31'd0, bad}, 32'd0);
         tick();
         chk("mfhi", aluResultOut, 32'd1);
         chk("mfhi wreg", {27'd0, writeRegOut}, 32'd4);
         chk("mfhi regWrite", {31'd0, regWriteOut}, 32'd1);
         drive(rType(6'h12, 32'd0, 32'd0, 5'd5, 5'b01000));
         tick();
         chk("mflo", aluResultOut, 32'hFFFF_FFFE);

         // Five hit-low cycles mid multiply extend the stall to 37.
         drive(rType(6'h19, 32'h1234_5678, 32'h10, 5'd0, 5'b01000));
         tick();
         drive(rType(6'h10, 32'd0, 32'd0, 5'd6, 5'b01000));
         cyc = 0;
         while (stall && cyc < 100) begin
            hit = (cyc >= 10 && cyc < 15) ? 1'b0 : 1'b1;
            cyc++;
            tick();
         end
         hit = 1'b1;
         chk("hit-low stall cycles", cyc, 32'd37);
         tick();
         chk("mfhi after hit-low", aluResultOut, 32'd1);
         drive(rType(6'h12, 32'd0, 32'd0, 5'd7, 5'b01000));
         tick();
         chk("mflo after hit-low", aluResultOut, 32'h2345_6780);

         // Reset at step 10 abandons the multiply and clears HI/LO.
         drive(rType(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'b01000));
         tick();
         for (int k = 0; k < 10; k++) tick();
         chk("stall before reset", {31'd0, stall}, 32'd1);
         RST = 1'b1;
         tick();
         RST = 1'b0;
         chk("stall after reset", {31'd0, stall}, 32'd0);
         drive(rType(6'h10, 32'd0, 32'd0, 5'd8, 5'b01000));
         tick();
         chk("mfhi after reset", aluResultOut, 32'd0);
         chk("mfhi after reset stall", {31'd0, stall}, 32'd0);
         drive(rType(6'h12, 32'd0, 32'd0, 5'd9, 5'b01000));
         tick();
         chk("mflo after reset", aluResultOut, 32'd0);
         chk("mflo after reset wreg", {27'd0, writeRegOut}, 32'd9);
      end
`else
      // Without the multiplier, multu/mfhi/mflo are plain unknown functs.
      drive(rType(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd21, 5'b01000));
      tick();
      chk("multu off res", aluResultOut, 32'd0);
      chk("multu off ctl", {27'd0, ctlOut()}, 32'b01000);
      chk("multu off stall", {31'd0, stall}, 32'd0);
      drive(rType(6'h10, 32'd3, 32'd4, 5'd4, 5'b01000));
      tick();
      chk("mfhi off res", aluResultOut, 32'd0);
      chk("mfhi off stall", {31'd0, stall}, 32'd0);
      drive(rType(6'h12, 32'd3, 32'd4, 5'd5, 5'b01000));
      tick();
      chk("mflo off res", aluResultOut, 32'd0);
      chk("mflo off wreg", {27'd0, writeRegOut}, 32'd5);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage plus EX/MEM pipeline register, fed directly by the ID/EX register. Decodes ALU control from `aluOp`/`funct`, computes the ALU result, zero flag, branch target and write-register index, and registers them with the MEM/WB control bits for the memory stage. Hosts an optional iterative unsigned multiplier with HI/LO registers that stalls the front end while busy.

## Interface
- `WIDTH`, 32: datapath width. Only 32 is supported; the parameter exists for lint checks.
- `CLK` in 1: clock. All state updates on the negedge.
- `RST` in 1: synchronous, active-high reset.
- `hit` in 1: global advance enable from the cache. When low, all state holds.
- `readData1`, `readData2` in 32: operands A and B from ID/EX.
- `signExImmediate` in 32: sign-extended immediate.
- `regDst`, `aluSrc`, `memToReg`, `regWrite`, `memRead`, `memWrite`, `branch` in 1 each: control bits from ID/EX.
- `aluOp` in 3: ALU operation class.
- `rt`, `rd` in 5 each: candidate destination registers.
- `funct` in 6: R-type function field.
- `nextPc` in 32: PC+4 of the instruction.
- `aluResultOut` out 32: registered ALU/HI/LO result.
- `writeDataOut` out 32: registered `readData2` (store data).
- `writeRegOut` out 5: registered destination, `regDst ? rd : rt`.
- `branchTargetOut` out 32: registered `nextPc + (signExImmediate << 2)`, modulo 2^32.
- `zeroOut` out 1: registered `aluResult == 0`.
- `memToRegOut`, `regWriteOut`, `memReadOut`, `memWriteOut`, `branchOut` out 1 each: registered control bits.
- `stall` out 1: multiplier busy. Upstream IF/ID and ID/EX advance only on `hit & ~stall`.

## Operation
- Operand B is `aluSrc ? signExImmediate : readData2`.
- `aluOp` encoding:
  - 000: add
  - 001: sub
  - 010: R-type, selected by `funct`
  - 011: and
  - 100: or
  - 101: signed slt, giving 1 or 0
  - 110: lui, giving B << 16
  - 111: add
- R-type `funct` encoding:
  - 0x20: add; 0x22: sub; 0x24: and; 0x25: or; 0x27: nor; 0x2A: signed slt
  - 0x10: mfhi; 0x12: mflo; 0x19: multu
  - Any other value: result 0, control passed unchanged.
- Add and sub wrap modulo 2^32. No overflow detection.
- multu (aluOp 010, funct 0x19) is accepted only in IDLE with `hit`=1 and `RST`=0.
  - The multu itself is registered with `regWriteOut`, `memReadOut`, `memWriteOut` and `branchOut` forced to 0.
- Multiplier FSM has states IDLE and BUSY.
  - IDLE → BUSY on multu acceptance. Latch A and B, clear the 64-bit accumulator, set counter to 0.
  - BUSY: each enabled edge performs one shift-add step on one multiplier bit (LSB first) and increments the counter.
  - BUSY → IDLE on the edge that completes step 32. On that edge HI ← product[63:32] and LO ← product[31:0].
- While BUSY, inputs are ignored. Every enabled edge loads a bubble into EX/MEM: all 1-bit control outputs and `zeroOut` are 0, and the data outputs hold their values.
- `stall` = (state == BUSY), taken from a register with no combinational input path.

## Timing
- Latency: the EX/MEM outputs reflect the inputs one negedge after capture.
- A multu captured at edge t0 makes `stall` high from t0 through t32, exactly 32 enabled cycles.
  - The instruction captured by ID/EX at t0 is held.
  - That instruction executes at edge t33 and sees the new HI/LO.
- `hit` low freezes everything: outputs, FSM state, counter, accumulator and HI/LO. Each low cycle during BUSY extends `stall` by one cycle.
- Reset is synchronous at an edge with `RST`=1 and has priority over `hit`. It sets:
  - every output, including `stall`, to 0
  - FSM to IDLE, counter to 0, HI/LO to 0
- Reset mid-multiply abandons the operation, and HI/LO read 0 afterwards.
- multu followed directly by mfhi/mflo gets the new value because of the stall. A second multu arriving during BUSY is impossible by construction because ID/EX is held.

## Configuration
- `EX_MULT_EN` defined: the multiplier FSM, HI/LO and the `stall` logic are compiled in as described above.
- `EX_MULT_EN` undefined:
  - funct 0x10, 0x12 and 0x19 behave as "other" (result 0).
  - No HI/LO registers and no FSM.
  - `stall` is tied to 0.
  - The port list is unchanged.

## Test plan
- Reset: hold `RST`=1 for one edge with random inputs → all outputs 0 and `stall`=0.
- R-type add: aluOp=010, funct=0x20, A=5, B=7, regDst=1, rd=3, regWrite=1 → next edge gives `aluResultOut`=12, `writeRegOut`=3, `zeroOut`=0, `regWriteOut`=1.
- beq: aluOp=001, A=B=9, nextPc=0x100, imm=4, branch=1 → `zeroOut`=1, `branchTargetOut`=0x110, `branchOut`=1.
- multu 0xFFFFFFFF×2 followed by mfhi, then mflo (`EX_MULT_EN` defined):
  - `stall` is high for exactly 32 cycles, with bubbles in EX/MEM.
  - mfhi then yields 1, and mflo yields 0xFFFFFFFE.
- `hit` low for 5 cycles mid-multiply → `stall` high for 37 cycles total, and the product is unchanged.
- `RST` at BUSY step 10 → `stall`=0 the next cycle, and a subsequent mfhi and mflo both give 0.
